// File: rtl/uart_fifo_param.sv
// -----------------------------------------------------------------------------
// uart_fifo_param
// Parametrised full-duplex UART with a show-ahead RX FIFO and sticky receive
// error flags. It sits between the RX/TX pins and the command processor.
//
// Parameters
//   DATA_BITS  : data bits per frame (5..9), sent LSB first
//   BAUD_DIV   : clocks per bit period (>= 4)
//   PARITY     : 0 = none, 1 = even, 2 = odd
//   STOP_BITS  : 1 or 2 stop bits
//   FIFO_DEPTH : RX FIFO entries, power of 2, >= 2
//
// Ports
//   clk        : system clock
//   rst        : synchronous active-high reset
//   RX         : serial input, asynchronous to clk
//   TX         : serial output, idles high
//   trmt       : start transmission of tx_data (ignored while busy)
//   tx_data    : word to transmit
//   tx_busy    : TX frame in progress
//   tx_done    : one-cycle pulse at the end of a TX frame
//   rx_rd      : pop RX FIFO head (ignored when empty)
//   rx_data    : RX FIFO head, valid while rx_rdy is high
//   rx_rdy     : RX FIFO not empty
//   rx_cnt     : RX FIFO occupancy, 0..FIFO_DEPTH
//   clr_err    : clear all sticky error flags (a same-cycle set wins)
//   parity_err : sticky, received parity mismatch
//   frame_err  : sticky, first stop bit sampled low
//   overrun    : sticky, word received while FIFO full and not popped
// -----------------------------------------------------------------------------
module uart_fifo_param #(
   parameter int DATA_BITS  = 8,
   parameter int BAUD_DIV   = 2604,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            RX,
   output logic                            TX,
   input  logic                            trmt,
   input  logic [DATA_BITS-1:0]            tx_data,
   output logic                            tx_busy,
   output logic                            tx_done,
   input  logic                            rx_rd,
   output logic [DATA_BITS-1:0]            rx_data,
   output logic                            rx_rdy,
   output logic [$clog2(FIFO_DEPTH):0]     rx_cnt,
   input  logic                            clr_err,
   output logic                            parity_err,
   output logic                            frame_err,
   output logic                            overrun
);

   localparam int BAUD_W = $clog2(BAUD_DIV);
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(BAUD_DIV / 2 - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // Parity bit that accompanies a data word in the configured mode.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
      return (PARITY == 2) ? ~(^word) : (^word);
   endfunction

   // ---------------------------------------------------------------- TX side
   uart_state_t            tx_state_r;
   logic [BAUD_W-1:0]      tx_baud_r;
   logic [BIT_W-1:0]       tx_bit_r;
   logic                   tx_stop_r;
   logic [DATA_BITS-1:0]   tx_shift_r;
   logic                   tx_par_r;

   // TX FSM: each bit is held BAUD_DIV cycles; TX/tx_busy/tx_done are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_r <= ST_IDLE;
         tx_baud_r  <= '0;
         tx_bit_r   <= '0;
         tx_stop_r  <= 1'b0;
         tx_shift_r <= '0;
         tx_par_r   <= 1'b0;
         TX         <= 1'b1;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (tx_state_r)
            ST_IDLE: begin
               // Also taken in the tx_done cycle, giving back-to-back frames.
               if (trmt) begin
                  tx_shift_r <= tx_data;
                  tx_par_r   <= parity_bit(tx_data);
                  tx_baud_r  <= '0;
                  TX         <= 1'b0;
                  tx_busy    <= 1'b1;
                  tx_state_r <= ST_START;
               end else begin
                  TX      <= 1'b1;
                  tx_busy <= 1'b0;
               end
            end
            ST_START: begin
               if (tx_baud_r == BAUD_LAST) begin
                  tx_baud_r  <= '0;
                  tx_bit_r   <= '0;
                  TX         <= tx_shift_r[0];
                  tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
                  tx_state_r <= ST_DATA;
               end else begin
                  tx_baud_r <= tx_baud_r + BAUD_W'(1);
               end
            end
            ST_DATA: begin
               if (tx_baud_r == BAUD_LAST) begin
                  tx_baud_r <= '0;
                  if (tx_bit_r == BIT_LAST) begin
                     if (PARITY != 0) begin
                        TX         <= tx_par_r;
                        tx_state_r <= ST_PARITY;
                     end else begin
                        TX         <= 1'b1;
                        tx_stop_r  <= 1'b0;
                        tx_state_r <= ST_STOP;
                     end
                  end else begin
                     tx_bit_r   <= tx_bit_r + BIT_W'(1);
                     TX         <= tx_shift_r[0];
                     tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
                  end
               end else begin
                  tx_baud_r <= tx_baud_r + BAUD_W'(1);
               end
            end
            ST_PARITY: begin
               if (tx_baud_r == BAUD_LAST) begin
                  tx_baud_r  <= '0;
                  tx_stop_r  <= 1'b0;
                  TX         <= 1'b1;
                  tx_state_r <= ST_STOP;
               end else begin
                  tx_baud_r <= tx_baud_r + BAUD_W'(1);
               end
            end
            ST_STOP: begin
               if (tx_baud_r == BAUD_LAST) begin
                  tx_baud_r <= '0;
                  if (tx_stop_r == STOP_LAST) begin
                     tx_busy    <= 1'b0;
                     tx_done    <= 1'b1;
                     tx_state_r <= ST_IDLE;
                  end else begin
                     tx_stop_r <= tx_stop_r + 1'b1;
                  end
               end else begin
                  tx_baud_r <= tx_baud_r + BAUD_W'(1);
               end
            end
            default: begin
               tx_state_r <= ST_IDLE;
               TX         <= 1'b1;
               tx_busy    <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- RX side
   logic                   rx_meta_r;
   logic                   rx_sync_r;
   logic                   rx_prev_r;
   uart_state_t            rx_state_r;
   logic [BAUD_W-1:0]      rx_baud_r;
   logic [BIT_W-1:0]       rx_bit_r;
   logic [DATA_BITS-1:0]   rx_shift_r;
   logic                   rx_par_r;
   logic                   rx_fall_s;

   // Two-flop synchroniser plus edge-history flop, preset to the idle level.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_prev_r <= 1'b1;
      end else begin
         rx_meta_r <= RX;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
      end
   end

   assign rx_fall_s = rx_prev_r & ~rx_sync_r;

   // RX FSM: half-period start qualification, then mid-bit sampling.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_r <= ST_IDLE;
         rx_baud_r  <= '0;
         rx_bit_r   <= '0;
         rx_shift_r <= '0;
         rx_par_r   <= 1'b0;
      end else begin
         case (rx_state_r)
            ST_IDLE: begin
               if (rx_fall_s) begin
                  rx_baud_r  <= '0;
                  rx_state_r <= ST_START;
               end
            end
            ST_START: begin
               if (rx_baud_r == HALF_LAST) begin
                  rx_baud_r <= '0;
                  rx_bit_r  <= '0;
                  // A high sample here is a glitch, not a start bit.
                  if (rx_sync_r) begin
                     rx_state_r <= ST_IDLE;
                  end else begin
                     rx_state_r <= ST_DATA;
                  end
               end else begin
                  rx_baud_r <= rx_baud_r + BAUD_W'(1);
               end
            end
            ST_DATA: begin
               if (rx_baud_r == BAUD_LAST) begin
                  rx_baud_r  <= '0;
                  rx_shift_r <= {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
                  if (rx_bit_r == BIT_LAST) begin
                     if (PARITY != 0) begin
                        rx_state_r <= ST_PARITY;
                     end else begin
                        rx_state_r <= ST_STOP;
                     end
                  end else begin
                     rx_bit_r <= rx_bit_r + BIT_W'(1);
                  end
               end else begin
                  rx_baud_r <= rx_baud_r + BAUD_W'(1);
               end
            end
            ST_PARITY: begin
               if (rx_baud_r == BAUD_LAST) begin
                  rx_baud_r  <= '0;
                  rx_par_r   <= rx_sync_r;
                  rx_state_r <= ST_STOP;
               end else begin
                  rx_baud_r <= rx_baud_r + BAUD_W'(1);
               end
            end
            ST_STOP: begin
               // Only the first stop bit is checked; idle from its midpoint.
               if (rx_baud_r == BAUD_LAST) begin
                  rx_baud_r  <= '0;
                  rx_state_r <= ST_IDLE;
               end else begin
                  rx_baud_r <= rx_baud_r + BAUD_W'(1);
               end
            end
            default: begin
               rx_state_r <= ST_IDLE;
               rx_baud_r  <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------- word disposition + FIFO
   logic [DATA_BITS-1:0]   fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_r;
   logic [PTR_W-1:0]       rd_ptr_r;
   logic                   stop_hit_s;
   logic                   word_ok_s;
   logic                   fifo_full_s;
   logic                   pop_s;
   logic                   push_s;
   logic                   par_set_s;
   logic                   frm_set_s;
   logic                   ovr_set_s;
   logic [CNT_W-1:0]       cnt_nxt_s;

   // Decide the fate of a received word at the stop sample.
   always_comb begin
      stop_hit_s  = (rx_state_r == ST_STOP) && (rx_baud_r == BAUD_LAST);
      word_ok_s   = stop_hit_s && rx_sync_r;
      fifo_full_s = (rx_cnt == FULL_CNT);
      pop_s       = rx_rd && (rx_cnt != '0);
      frm_set_s   = stop_hit_s && !rx_sync_r;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      if (word_ok_s && (!fifo_full_s || pop_s)) begin
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end
      ovr_set_s = word_ok_s && fifo_full_s && !pop_s;
      if (PARITY != 0) begin
         par_set_s = word_ok_s && (rx_par_r != parity_bit(rx_shift_r));
      end else begin
         par_set_s = 1'b0;
      end
   end

   // Next FIFO occupancy from push/pop.
   always_comb begin
      cnt_nxt_s = rx_cnt;
      case ({push_s, pop_s})
         2'b10:   cnt_nxt_s = rx_cnt + CNT_W'(1);
         2'b01:   cnt_nxt_s = rx_cnt - CNT_W'(1);
         default: cnt_nxt_s = rx_cnt;
      endcase
   end

   // FIFO storage, wrapping pointers and registered occupancy/ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         rx_cnt   <= '0;
         rx_rdy   <= 1'b0;
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= rx_shift_r;
            wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         rx_cnt <= cnt_nxt_s;
         rx_rdy <= (cnt_nxt_s != '0);
      end
   end

   assign rx_data = fifo_mem_r[rd_ptr_r];

   // Sticky error flags; a set event takes priority over clr_err.
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (par_set_s) begin
            parity_err <= 1'b1;
         end else if (clr_err) begin
            parity_err <= 1'b0;
         end
         if (frm_set_s) begin
            frame_err <= 1'b1;
         end else if (clr_err) begin
            frame_err <= 1'b0;
         end
         if (ovr_set_s) begin
            overrun <= 1'b1;
         end else if (clr_err) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: doc/uart_fifo_param.md
Name: uart_fifo_param

Overview:
Parametrised full-duplex UART, successor to the fixed 8N1 transceiver used by the command/telemetry path. It has configurable data width, baud divisor, parity mode and stop-bit count. The receive side has a show-ahead RX FIFO and sticky error flags (parity, framing, overrun). It sits between the top-level RX/TX pins and the command processor, and replaces the single-byte rx_rdy/clr_rx_rdy handshake with a FIFO pop interface.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
BAUD_DIV, 2604, clocks per bit period, >=4 (2604 = 50 MHz / 19200)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame, 1 or 2
FIFO_DEPTH, 4, RX FIFO entries, power of 2, >=2

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
RX  input  1  serial in, asynchronous to clk
TX  output  1  serial out, idles high
trmt  input  1  start transmission of tx_data
tx_data  input  DATA_BITS  word to transmit
tx_busy  output  1  TX frame in progress
tx_done  output  1  one-cycle pulse at end of frame
rx_rd  input  1  pop RX FIFO head
rx_data  output  DATA_BITS  RX FIFO head (show-ahead)
rx_rdy  output  1  RX FIFO not empty
rx_cnt  output  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
clr_err  input  1  clear all error flags
parity_err  output  1  sticky: received parity mismatch
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: word received while FIFO full

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. rst is honoured in any state, including mid-frame.
- Reset state:
  - TX=1, tx_busy=0, tx_done=0.
  - FIFO empty: rx_rdy=0, rx_cnt=0, rx_data=0.
  - All error flags 0; both FSMs in IDLE.
  - RX synchroniser flops preset to 1.
- Frame format: start bit (0), DATA_BITS LSB-first, optional parity bit, STOP_BITS stop bits (1). Total N = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bit periods, each BAUD_DIV clocks.
- Parity: even means the XOR of data bits and parity bit is 0; odd means it is 1.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - IDLE & trmt: latch tx_data; TX goes low and tx_busy goes high on the next cycle.
  - Each bit is held exactly BAUD_DIV cycles. PARITY is skipped when PARITY=0. STOP runs STOP_BITS periods.
  - At the end of the final stop period: back to IDLE, tx_busy=0, tx_done=1 for exactly 1 cycle.
  - trmt while busy is ignored (no queueing, latched word unchanged).
  - trmt in the same cycle tx_done pulses is accepted: back-to-back frames with no idle gap.
- RX FSM (IDLE, START, DATA, PARITY, STOP):
  - RX passes through a 2-flop synchroniser. Falling edge of the synced RX in IDLE enters START.
  - START waits BAUD_DIV/2 (integer) and samples. If the sample is 1, it is a false start: return to IDLE with no flags set.
  - Otherwise sample every BAUD_DIV thereafter, at mid-bit, for data, parity and stop bits. With STOP_BITS=2 only the first stop bit is checked.
  - After the stop sample, return to IDLE immediately; the next start edge is detected from there.
- Word disposition at the stop sample:
  - Stop bit = 0: set frame_err, discard the word.
  - Else, parity mismatch: set parity_err, still push the word.
  - Else, FIFO full and no pop this cycle: set overrun, discard the word. FIFO contents are unchanged.
- RX FIFO:
  - Circular buffer with read/write pointers.
  - rx_data is the head entry, valid whenever rx_rdy=1.
  - rx_rd pops the head; rx_rd when empty is ignored.
  - Push and pop in the same cycle: both succeed, rx_cnt unchanged. This includes the full case, so no overrun.
  - Pointers wrap modulo FIFO_DEPTH. rx_cnt ranges 0..FIFO_DEPTH.
- Error flags:
  - Set only by the events above. Cleared only by clr_err or rst.
  - Set and clr_err in the same cycle: set wins.

Test Plan:
1. DATA_BITS=8, BAUD_DIV=16, PARITY=1, STOP_BITS=1, TX looped to RX; trmt with tx_data=8'hA5 -> TX low for 16 cycles, then bits 1,0,1,0,0,1,0,1, parity 0, stop 1; tx_done pulses 1 cycle at cycle 176; rx_rdy=1, rx_data=8'hA5, no flags.
2. Send 5 words 8'h01..8'h05 with no rx_rd, FIFO_DEPTH=4 -> rx_cnt=4, overrun=1, pops return 01,02,03,04, then rx_rdy=0; clr_err -> overrun=0.
3. Drive an RX frame with a wrong parity bit for 8'h3C -> parity_err=1, 8'h3C is in the FIFO; drive a frame with stop bit 0 -> frame_err=1, rx_cnt unchanged.
4. Pulse RX low for 4 cycles (< BAUD_DIV/2) -> RX FSM returns to IDLE, rx_cnt=0, no flags; a following valid frame 8'h5A is received correctly.
5. FIFO full, rx_rd asserted in the same cycle as a new stop sample -> rx_cnt stays 4, overrun=0, new word at tail; also assert rx_rd when empty -> no change.
6. Assert rst mid TX frame and mid RX frame -> next cycle TX=1, tx_busy=0, FIFO empty, flags 0; new trmt with tx_data=8'hFF is transmitted cleanly; repeat test 1 with PARITY=2, STOP_BITS=2, DATA_BITS=9 -> parity bit inverted, frame length 13*16 cycles.
